// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared external ALU: IDLE -> EXEC -> RESP, one operation per 3 cycles.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default build is round-robin.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [3:0]        op0,
    input  logic [3:0]        op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] res,
    output logic              zero,
    output logic              ovf,
    output logic              busy,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_opnd1,
    output logic [DATA_W-1:0] alu_opnd2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   owner;
    logic   win;
    logic   take;

    assign take = req0 | req1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win = req1 & ~req0;
`else
    // last_owner resets to 1 so requester 0 wins the first contention
    logic last_owner;

    always_comb begin
        if (req0 && req1) begin
            win = ~last_owner;
        end else begin
            win = req1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= 1'b1;
        end else if (state == IDLE && take) begin
            last_owner <= win;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                busy      = 1'b1;
                gnt0      = ~owner;
                gnt1      = owner;
                state_nxt = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                done0     = ~owner;
                done1     = owner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            alu_opcode <= '0;
            alu_opnd1  <= '0;
            alu_opnd2  <= '0;
            res        <= '0;
            zero       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (state == IDLE && take) begin
                owner      <= win;
                alu_opcode <= win ? op1 : op0;
                alu_opnd1  <= win ? a1 : a0;
                alu_opnd2  <= win ? b1 : b0;
            end
            if (state == EXEC) begin
                res  <= alu_out;
                zero <= alu_zero;
                ovf  <= alu_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural model of the shared ALU and a result scoreboard.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         req0, req1;
    logic [3:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1;
    logic [W-1:0] res;
    logic         zero, ovf, busy;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_opnd1, alu_opnd2;
    logic [W-1:0] alu_out;
    logic         alu_zero, alu_ovf;

    typedef struct {
        logic         who;
        logic [W-1:0] res;
        logic         z;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .zero(zero), .ovf(ovf), .busy(busy),
        .alu_opcode(alu_opcode), .alu_opnd1(alu_opnd1), .alu_opnd2(alu_opnd2),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: unsigned carry/borrow/high-product as overflow; unused opcodes add
    logic [2*W-1:0] prod;
    logic [W:0]     wide;
    always_comb begin
        prod = '0;
        wide = '0;
        alu_ovf = 1'b0;
        case (alu_opcode)
            4'b0001: begin
                wide = {1'b0, alu_opnd1} - {1'b0, alu_opnd2};
                alu_ovf = alu_opnd1 < alu_opnd2;
            end
            4'b0010: begin
                prod = {{W{1'b0}}, alu_opnd1} * {{W{1'b0}}, alu_opnd2};
                wide = {1'b0, prod[W-1:0]};
                alu_ovf = |prod[2*W-1:W];
            end
            4'b0011: wide = {1'b0, alu_opnd1 & alu_opnd2};
            4'b0100: wide = {1'b0, alu_opnd1 | alu_opnd2};
            default: begin
                wide = {1'b0, alu_opnd1} + {1'b0, alu_opnd2};
                alu_ovf = wide[W];
            end
        endcase
        alu_out  = wide[W-1:0];
        alu_zero = (alu_out == '0);
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then score any done pulse against the oldest expectation
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        chk("gnt_exclusive", {31'b0, gnt0 & gnt1}, '0);
        if (done0 || done1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {30'b0, done1, done0}, '0);
            end else begin
                e = sb.pop_front();
                chk("done_owner", {30'b0, done1, done0}, e.who ? 32'd2 : 32'd1);
                chk("res", res, e.res);
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                chk("ovf", {31'b0, ovf}, {31'b0, e.o});
            end
        end
    endtask

    task automatic push(input logic who, input logic [W-1:0] r, input logic z, input logic o);
        exp_t e;
        e.who = who;
        e.res = r;
        e.z   = z;
        e.o   = o;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'b0, gnt1, gnt0}, '0);
        chk({tag, "_done"}, {30'b0, done1, done0}, '0);
        chk({tag, "_busy"}, {31'b0, busy}, '0);
        chk({tag, "_res"}, res, '0);
        chk({tag, "_flags"}, {30'b0, zero, ovf}, '0);
        chk({tag, "_alu_opcode"}, {28'b0, alu_opcode}, '0);
        chk({tag, "_alu_opnd1"}, alu_opnd1, '0);
        chk({tag, "_alu_opnd2"}, alu_opnd2, '0);
    endtask

    task automatic run_op(input logic who, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                          input logic eo);
        push(who, er, ez, eo);
        if (who) begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end
        step();
        chk("exec_gnt", {30'b0, gnt1, gnt0}, who ? 32'd2 : 32'd1);
        chk("exec_busy", {31'b0, busy}, 32'd1);
        chk("exec_alu_opcode", {28'b0, alu_opcode}, {28'b0, op});
        chk("exec_alu_opnd1", alu_opnd1, a);
        chk("exec_alu_opnd2", alu_opnd2, b);
        req0 = 1'b0;
        req1 = 1'b0;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        op0 = 4'($urandom); op1 = 4'($urandom);
        step();
        chk("resp_done", {30'b0, done1, done0}, who ? 32'd2 : 32'd1);
        chk("resp_gnt", {30'b0, gnt1, gnt0}, '0);
        step();
        chk("idle_busy", {31'b0, busy}, '0);
        chk("hold_alu_opnd1", alu_opnd1, a);
        chk("hold_res", res, er);
    endtask

    logic exp_w2;

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        run_op(1'b0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        run_op(1'b1, 4'b0001, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0);
        run_op(1'b0, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1);
        run_op(1'b1, 4'b0010, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        run_op(1'b0, 4'b0011, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0);
        run_op(1'b1, 4'b0100, 32'hA0, 32'h05, 32'hA5, 1'b0, 1'b0);
        run_op(1'b0, 4'b0111, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);

        // Contention straight after reset: requester 0 first, then the pointer decides
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_w2 = 1'b0;
`else
        exp_w2 = 1'b1;
`endif
        push(1'b0, 32'd3, 1'b0, 1'b0);
        push(exp_w2, exp_w2 ? 32'hA5 : 32'd3, 1'b0, 1'b0);
        req0 = 1'b1; op0 = 4'b0000; a0 = 32'd1; b0 = 32'd2;
        req1 = 1'b1; op1 = 4'b0100; a1 = 32'hA0; b1 = 32'h05;
        step();
        chk("cont_gnt_n1", {30'b0, gnt1, gnt0}, 32'd1);
        step();
        step();
        chk("cont_idle_n3", {31'b0, busy}, '0);
        step();
        chk("cont_gnt_n4", {30'b0, gnt1, gnt0}, exp_w2 ? 32'd2 : 32'd1);
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        step();

        // An uncontended grant to 0 must also move the pointer
        run_op(1'b0, 4'b0000, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
        push(exp_w2, exp_w2 ? 32'hA5 : 32'd3, 1'b0, 1'b0);
        req0 = 1'b1; op0 = 4'b0000; a0 = 32'd1; b0 = 32'd2;
        req1 = 1'b1; op1 = 4'b0100; a1 = 32'hA0; b1 = 32'h05;
        step();
        chk("cont2_gnt", {30'b0, gnt1, gnt0}, exp_w2 ? 32'd2 : 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();

        // Reset in EXEC aborts the operation with no done pulse
        req0 = 1'b1; op0 = 4'b0000; a0 = 32'd9; b0 = 32'd9;
        step();
        chk("abort_gnt", {30'b0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0;
        rst = 1'b1;
        step();
        chk_all_zero("abort");
        rst = 1'b0;
        step();
        chk("abort_no_done", {30'b0, done1, done0}, '0);
        step();
        run_op(1'b1, 4'b0000, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0);

        chk("sb_empty", sb.size(), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports req0/req1, input, 1 each, request from requester 0/1.
REQ-005 SHALL have ports op0/op1, input, 4 each, ALU opcode per requester (0000 add, 0001 sub, 0010 mul, 0011 and, 0100 or).
REQ-006 SHALL have ports a0/b0/a1/b1, input, DATA_W each, operands per requester.
REQ-007 SHALL have ports gnt0/gnt1, output, 1 each, one-cycle grant pulse.
REQ-008 SHALL have ports done0/done1, output, 1 each, one-cycle result-valid pulse.
REQ-009 SHALL have ports res (output, DATA_W), zero (output, 1) and ovf (output, 1): registered result, zero flag and overflow flag.
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 SHALL have ports alu_opcode (output, 4), alu_opnd1 and alu_opnd2 (output, DATA_W each) driving the shared ALU.
REQ-012 SHALL have ports alu_out (input, DATA_W), alu_zero (input, 1) and alu_ovf (input, 1) returned from the shared ALU.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; transitions IDLE->EXEC on any sampled request, EXEC->RESP and RESP->IDLE unconditionally.
REQ-014 SHALL, in IDLE with at least one req high at edge N, latch the winner's opcode/operands into alu_opcode/alu_opnd1/alu_opnd2 and record the owner at that edge.
REQ-015 SHALL assert the owner's gnt in cycle N+1 (EXEC) only; never both gnt0 and gnt1.
REQ-016 SHALL capture alu_out, alu_zero and alu_ovf into res, zero and ovf at the edge leaving EXEC.
REQ-017 SHALL assert the owner's done in cycle N+2 (RESP) only, with res/zero/ovf valid in that cycle.
REQ-018 SHALL hold res/zero/ovf and alu_opcode/alu_opnd1/alu_opnd2 unchanged until the next capture or latch.
REQ-019 SHALL ignore requests outside IDLE; a requester holds req until its gnt, and may drop or keep it afterwards.
REQ-020 SHALL arbitrate round-robin when both requests are high: the requester not served last wins.
REQ-021 SHALL give throughput of one operation per 3 cycles; a requester holding req continuously may be regranted at edge N+3.
REQ-022 SHALL pass opcodes through unmodified; the unused codes 0101-1111 reach the ALU, which executes them as add.

Reset
REQ-023 SHALL, with rst high at an edge, enter IDLE and clear gnt0/gnt1, done0/done1, busy, res, zero, ovf, alu_opcode, alu_opnd1 and alu_opnd2 to 0.
REQ-024 SHALL reset the round-robin pointer so requester 0 wins the first contention.
REQ-025 SHALL abort any in-flight operation on reset mid-EXEC or mid-RESP, with no done pulse issued for it.

Configuration
REQ-026 SHALL, with macro ALU_ARB_FIXED_PRIO_EN defined, use fixed priority (requester 0 always wins contention; no pointer state).
REQ-027 SHALL, without ALU_ARB_FIXED_PRIO_EN, use the round-robin arbitration of REQ-020/REQ-024.

Verification
REQ-028 SHALL cover: req0=1, op0=0000, a0=5, b0=7 -> gnt0 at N+1, done0 at N+2, res=12, zero=0, ovf=0.
REQ-029 SHALL cover: req1=1, op1=0001, a1=b1=0x1234 -> done1 at N+2, res=0, zero=1.
REQ-030 SHALL cover: req0=req1=1 held for 6 cycles (round-robin) -> gnt0 at N+1, gnt1 at N+4; with ALU_ARB_FIXED_PRIO_EN -> gnt0 at both N+1 and N+4.
REQ-031 SHALL cover: op0=0000, a0=0xFFFFFFFF, b0=1 -> res=0, zero=1, ovf=1.
REQ-032 SHALL cover: rst pulsed during EXEC -> no done pulse, all outputs 0 next cycle, and a new req is granted normally afterwards.
